dac_offset_binary_tx: RTL and testbench

DAC_OFFSET_BINARY_TX -- requirements
Module: dac_offset_binary_tx

---
 rtl/dac_offset_binary_tx_pkg.sv | 12 +
 rtl/conv_sign_to_unsign.sv | 20 ++
 rtl/dac_offset_binary_tx.sv | 115 +++++++++++
 tb/tb_dac_offset_binary_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/dac_offset_binary_tx_pkg.sv
// Shared constants for the offset-binary DAC transmitter.
package dac_offset_binary_tx_pkg;

   localparam int unsigned N_DEFAULT = 14;

   // Midscale code (signed zero after conversion) at the default width
   localparam logic [N_DEFAULT-1:0] MIDSCALE_DEFAULT = {1'b1, {(N_DEFAULT-1){1'b0}}};

   localparam int unsigned UNDERRUN_CNT_W = 8;
   localparam logic [UNDERRUN_CNT_W-1:0] UNDERRUN_CNT_MAX = '1;

endpackage

// File: rtl/conv_sign_to_unsign.sv
// Two's-complement to offset-binary conversion with a symmetric range:
// the two most negative codes both map to the bottom DAC code.
module conv_sign_to_unsign #(
   parameter int unsigned N = 14
) (
   input  logic [N-1:0] s,
   output logic [N-1:0] u_c
);

   localparam logic [N-1:0] NEG_FULL = {1'b1, {(N-1){1'b0}}};

   // Invert MSB; clamp 100..00 and 100..01 to zero
   always_comb begin
      u_c = {~s[N-1], s[N-2:0]};
      if (s[N-1:1] == NEG_FULL[N-1:1]) begin
         u_c = '0;
      end
   end

endmodule

// File: rtl/dac_offset_binary_tx.sv
// Sample FIFO feeding a DAC at a divided tick rate, with underrun tracking.
module dac_offset_binary_tx
   import dac_offset_binary_tx_pkg::*;
#(
   parameter int unsigned N     = N_DEFAULT,
   parameter int unsigned DIV   = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [N-1:0]              in_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [N-1:0]              dac_data,
   output logic                      dac_strobe,
   output logic                      underrun,
   output logic [UNDERRUN_CNT_W-1:0] underrun_cnt,
   input  logic                      underrun_clr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [N-1:0] MIDSCALE = {1'b1, {(N-1){1'b0}}};

   logic [N-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [TW-1:0] tick_cnt;
   logic [N-1:0]  head_u_c;
   logic          empty_c;
   logic          full_c;
   logic          push_c;
   logic          tick_c;
   logic          pop_c;
   logic          urun_c;

   // Pointer-derived status; extra pointer bit separates full from empty
   always_comb begin
      empty_c = (wr_ptr == rd_ptr);
      full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      push_c  = in_valid && !full_c;
      tick_c  = enable && (tick_cnt == TW'(DIV - 1));
      pop_c   = tick_c && !empty_c;
      urun_c  = tick_c && empty_c;
   end

   assign in_ready = ~full_c;

   // Conversion on the FIFO head
   conv_sign_to_unsign #(.N(N)) u_conv (
      .s   (mem[rd_ptr[AW-1:0]]),
      .u_c (head_u_c)
   );

   // Tick divider, parked at zero while disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (!enable || tick_c) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push_c) begin
         mem[wr_ptr[AW-1:0]] <= in_data;
      end
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_c) wr_ptr <= wr_ptr + PW'(1);
         if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // DAC output register and strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac_data   <= MIDSCALE;
         dac_strobe <= 1'b0;
      end else begin
         dac_strobe <= tick_c;
         if (pop_c) dac_data <= head_u_c;
      end
   end

   // Underrun flag and saturating counter; a new underrun outranks clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else if (urun_c) begin
         underrun <= 1'b1;
         if (underrun_clr) begin
            underrun_cnt <= UNDERRUN_CNT_W'(1);
         end else if (underrun_cnt != UNDERRUN_CNT_MAX) begin
            underrun_cnt <= underrun_cnt + UNDERRUN_CNT_W'(1);
         end
      end else if (underrun_clr) begin
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end
   end

endmodule

// File: tb/tb_dac_offset_binary_tx.sv
// Directed scoreboard bench for dac_offset_binary_tx (N=14, DIV=4, DEPTH=4).
module tb_dac_offset_binary_tx;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [13:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [13:0] dac_data;
   logic        dac_strobe;
   logic        underrun;
   logic [7:0]  underrun_cnt;
   logic        underrun_clr;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [13:0] exp_q[$];
   logic [13:0] last_exp;

   dac_offset_binary_tx #(.N(14), .DIV(4), .DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .dac_data     (dac_data),
      .dac_strobe   (dac_strobe),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .underrun_clr (underrun_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for the next strobe; gap = negedges waited
   task automatic wait_strobe(input string tag, output int gap);
      gap = 0;
      while (gap < 16) begin
         @(negedge clk);
         gap++;
         if (dac_strobe === 1'b1) break;
      end
      if (dac_strobe !== 1'b1) check({tag, "_timeout"}, 32'(dac_strobe), 32'd1);
   endtask

   // Wait for a strobe and compare against the scoreboard head
   task automatic strobe_check(input string tag, input int exp_gap, input bit chk_gap);
      int          gap;
      logic [13:0] exp;
      wait_strobe(tag, gap);
      if (chk_gap) check({tag, "_gap"}, 32'(gap), 32'(exp_gap));
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
         exp = exp_q.pop_front();
         last_exp = exp;
         check({tag, "_data"}, 32'(dac_data), 32'(exp));
      end
   endtask

   initial begin
      logic [13:0] vals [5];
      int gap;
      rst_n        = 1'b0;
      enable       = 1'b0;
      in_data      = '0;
      in_valid     = 1'b0;
      underrun_clr = 1'b0;
      last_exp     = 14'h2000;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_dac_data", 32'(dac_data), 32'h2000);
      check("rst_strobe", 32'(dac_strobe), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_underrun", 32'(underrun), 32'd0);
      check("rst_underrun_cnt", 32'(underrun_cnt), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Conversion boundaries, strobes exactly DIV apart
      vals[0] = 14'h0000; vals[1] = 14'h1FFF; vals[2] = 14'h2000; vals[3] = 14'h2001;
      exp_q.push_back(14'h2000); exp_q.push_back(14'h3FFF);
      exp_q.push_back(14'h0000); exp_q.push_back(14'h0000);
      for (int i = 0; i < 4; i++) begin
         check("conv_push_ready", 32'(in_ready), 32'd1);
         in_valid = 1'b1;
         in_data  = vals[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      enable   = 1'b1;
      for (int i = 0; i < 4; i++) strobe_check("conv", 4, 1'b1);
      enable = 1'b0;
      repeat (6) @(negedge clk);
      check("conv_no_underrun", 32'(underrun), 32'd0);
      check("conv_no_strobe", 32'(dac_strobe), 32'd0);

      // Fill to full with enable low; fifth push refused
      vals[0] = 14'h0123; vals[1] = 14'h3000; vals[2] = 14'h2001;
      vals[3] = 14'h1FFF; vals[4] = 14'h0AAA;
      exp_q.push_back(14'h2123); exp_q.push_back(14'h1000);
      exp_q.push_back(14'h0000); exp_q.push_back(14'h3FFF);
      for (int i = 0; i < 5; i++) begin
         check("full_in_ready", 32'(in_ready), (i < 4) ? 32'd1 : 32'd0);
         in_valid = 1'b1;
         in_data  = vals[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      enable   = 1'b1;
      for (int i = 0; i < 4; i++) strobe_check("full_order", 4, 1'b1);
      check("full_ready_after", 32'(in_ready), 32'd1);
      check("full_underrun_after", 32'(underrun), 32'd0);

      // Underrun: held data, counter saturates at 255
      for (int k = 1; k <= 300; k++) begin
         exp_q.push_back(last_exp);
         strobe_check("urun", 4, 1'b1);
         check("urun_flag", 32'(underrun), 32'd1);
         check("urun_cnt", 32'(underrun_cnt), (k > 255) ? 32'd255 : 32'(k));
      end

      // Clear away from a tick
      underrun_clr = 1'b1;
      @(negedge clk);
      underrun_clr = 1'b0;
      check("clr_flag", 32'(underrun), 32'd0);
      check("clr_cnt", 32'(underrun_cnt), 32'd0);

      // Clear coincident with an underrun tick
      repeat (2) @(negedge clk);
      underrun_clr = 1'b1;
      exp_q.push_back(last_exp);
      strobe_check("clr_tick", 1, 1'b1);
      underrun_clr = 1'b0;
      check("clr_tick_flag", 32'(underrun), 32'd1);
      check("clr_tick_cnt", 32'(underrun_cnt), 32'd1);
      enable = 1'b0;

      // Reset with samples queued
      vals[0] = 14'h0555; vals[1] = 14'h1555; vals[2] = 14'h2555;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = vals[i];
         @(negedge clk);
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mid_rst_dac_data", 32'(dac_data), 32'h2000);
      check("mid_rst_strobe", 32'(dac_strobe), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd1);
      check("mid_rst_underrun", 32'(underrun), 32'd0);
      check("mid_rst_cnt", 32'(underrun_cnt), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      check("rel_no_strobe", 32'(dac_strobe), 32'd0);
      last_exp = 14'h2000;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(last_exp);
         strobe_check("post_rst", 3, i == 0);
         check("post_rst_underrun", 32'(underrun), 32'd1);
         check("post_rst_cnt", 32'(underrun_cnt), 32'(i + 1));
      end
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      gap = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
